sb_cache_arbiter: RTL
=====================

// Module: sb_cache_arbiter
// PURPOSE
//  Controller sharing the single D-cache port between the load path and the store buffer drain.
//  Sits between store_buffer and the data cache; decides each cycle who owns the port.
//  Loads win by default; store buffer entries drain in the background, one per cache handshake.
//  Forces drain on full buffer or flush request (syscall/exception fence); stalls stores when full.
// PARAMETERS
//  SB_NLINES     4  store buffer entries (matches `SB_NLINES)
//  CNT_W         3  occupancy width, $clog2(SB_NLINES)+1
//  STARVE_LIMIT  8  consecutive load grants before a forced drain (only with SB_ARB_STARVE_GUARD_EN)
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-low reset
//  sb_count    in   CNT_W  current store buffer occupancy (0..SB_NLINES)
//  is_store    in   1      store in current pipeline stage wants an SB entry
//  ld_req      in   1      load needs the cache port; held until ld_gnt
//  flush       in   1      one-cycle request: drain the buffer completely
//  cache_ack   in   1      cache completes current access (one-cycle pulse)
//  cache_req   out  1      access valid toward cache; held until cache_ack
//  cache_we    out  1      1 = store drain write, 0 = load read
//  ld_gnt      out  1      one-cycle pulse: load access completed
//  sb_pop      out  1      one-cycle pulse: SB head written to cache, retire it
//  sb_stall    out  1      stall pipeline: store cannot enter a full buffer
//  flush_done  out  1      one-cycle pulse: flush finished, buffer empty
// BEHAVIOUR
//  - reset low: state IDLE, flush_pend=0, starve_cnt=0; all outputs 0 immediately (async), incl. mid-access.
//  - FSM states IDLE, LOAD, DRAIN; cache_req/cache_we Moore-decoded from state.
//  - IDLE decision, evaluated in priority order each cycle:
//      1) flush_pend & sb_count==0 -> flush_done=1 (combinational), flush_pend clears at edge, stay IDLE
//      2) sb_count>0 & (sb_count==SB_NLINES | flush_pend | starve) -> DRAIN
//      3) ld_req -> LOAD
//      4) sb_count>0 -> DRAIN
//      5) else stay IDLE
//  - LOAD: cache_req=1, cache_we=0; on cache_ack: ld_gnt=1 same cycle, -> IDLE.
//  - DRAIN: cache_req=1, cache_we=1; on cache_ack: sb_pop=1 same cycle, -> IDLE.
//  - min latency: decision cycle + ack cycle => one access per 2 cycles; no back-to-back requests.
//  - no timeout: state holds indefinitely until cache_ack; cache_ack outside LOAD/DRAIN is ignored.
//  - flush sets flush_pend at edge; flush while flush_pend is absorbed (single flush_done).
//  - flush with empty buffer in IDLE: flush_done in the next cycle.
//  - flush_pend blocks new loads; a LOAD already in flight completes normally.
//  - sb_stall = is_store & (sb_count==SB_NLINES) & ~sb_pop (combinational); pop and push in the same cycle are legal.
//  - sb_count changes only through sb_pop/push in store_buffer; the arbiter never reads data or address.
// CONFIGURATION
//  SB_ARB_STARVE_GUARD_EN defined:
//    starve_cnt (width $clog2(STARVE_LIMIT+1)) increments on each ld_gnt while sb_count>0.
//    starve = (starve_cnt==STARVE_LIMIT); starve_cnt clears on sb_pop or sb_count==0; saturates.
//  undefined: starve tied 0, no counter; loads always win unless buffer full or flush pending.
// TESTING
//  1 reset=0 with ld_req=1, sb_count=2 -> all outputs 0; release reset -> LOAD chosen first (cache_we=0).
//  2 sb_count=3, ld_req=0, bench acks in the first req cycle and decrements count -> sb_pop at cycles 2,4,6; idle after.
//  3 sb_count=4, is_store=1, ld_req=1 -> sb_stall=1; DRAIN wins over load; sb_stall=0 in ack cycle; LOAD next.
//  4 flush pulse, sb_count=2, ld_req held -> two drains, flush_done one cycle, then ld_gnt; second flush mid-way ignored.
//  5 GUARD_EN, STARVE_LIMIT=8, sb_count=1, ld_req always, immediate ack -> 8 ld_gnt then 1 sb_pop; without macro, no pop.
//  6 reset=0 during DRAIN with cache_req=1 -> cache_req=0 same cycle, no sb_pop; after release IDLE, flush_pend=0.

Source files
------------

// File: rtl/sb_cache_arbiter.sv
// Arbiter for the single D-cache port: load path versus store buffer drain.
// Optional starvation guard enabled by defining SB_ARB_STARVE_GUARD_EN.
module sb_cache_arbiter #(
  parameter int SB_NLINES    = 4,
  parameter int CNT_W        = $clog2(SB_NLINES) + 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] sb_count,
  input  logic             is_store,
  input  logic             ld_req,
  input  logic             flush,
  input  logic             cache_ack,
  output logic             cache_req,
  output logic             cache_we,
  output logic             ld_gnt,
  output logic             sb_pop,
  output logic             sb_stall,
  output logic             flush_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SB_FULL = CNT_W'(SB_NLINES);

  state_t state_r;
  logic   cache_req_r;
  logic   cache_we_r;
  logic   flush_pend_r;
  logic   sb_nonempty_s;
  logic   sb_full_s;
  logic   starve_s;

  assign sb_nonempty_s = (sb_count != {CNT_W{1'b0}});
  assign sb_full_s     = (sb_count == SB_FULL);

  assign cache_req  = cache_req_r;
  assign cache_we   = cache_we_r;
  assign ld_gnt     = (state_r == LOAD)  & cache_ack;
  assign sb_pop     = (state_r == DRAIN) & cache_ack;
  assign flush_done = (state_r == IDLE)  & flush_pend_r & ~sb_nonempty_s;
  // Gated by reset so the stall also drops immediately while reset is held.
  assign sb_stall   = reset & is_store & sb_full_s & ~sb_pop;

`ifdef SB_ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] starve_cnt_r;

  assign starve_s = (starve_cnt_r == SC_MAX);

  // Consecutive-load counter; saturates so a forced drain stays requested.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= {SC_W{1'b0}};
    end else if (sb_pop || !sb_nonempty_s) begin
      starve_cnt_r <= {SC_W{1'b0}};
    end else if (ld_gnt && !starve_s) begin
      starve_cnt_r <= starve_cnt_r + {{(SC_W-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  assign starve_s = 1'b0;
`endif

  // Port ownership FSM with registered request/write-enable and flush tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cache_req_r  <= 1'b0;
      cache_we_r   <= 1'b0;
      flush_pend_r <= 1'b0;
    end else begin
      // A flush arriving while one is pending (or finishing) is absorbed.
      flush_pend_r <= flush_done ? 1'b0 : (flush_pend_r | flush);
      case (state_r)
        IDLE: begin
          if (flush_done) begin
            state_r     <= IDLE;
            cache_req_r <= 1'b0;
            cache_we_r  <= 1'b0;
          end else if (sb_nonempty_s && (sb_full_s || flush_pend_r || starve_s)) begin
            state_r     <= DRAIN;
            cache_req_r <= 1'b1;
            cache_we_r  <= 1'b1;
          end else if (ld_req) begin
            state_r     <= LOAD;
            cache_req_r <= 1'b1;
            cache_we_r  <= 1'b0;
          end else if (sb_nonempty_s) begin
            state_r     <= DRAIN;
            cache_req_r <= 1'b1;
            cache_we_r  <= 1'b1;
          end else begin
            state_r     <= IDLE;
            cache_req_r <= 1'b0;
            cache_we_r  <= 1'b0;
          end
        end
        LOAD, DRAIN: begin
          if (cache_ack) begin
            state_r     <= IDLE;
            cache_req_r <= 1'b0;
            cache_we_r  <= 1'b0;
          end else begin
            state_r     <= state_r;
            cache_req_r <= cache_req_r;
            cache_we_r  <= cache_we_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          cache_req_r <= 1'b0;
          cache_we_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
